// File: rtl/box_muller_gauss_out.sv
// Final Box-Muller stage: pairs one magnitude with one sin/cos sample, forms
// x0 = f*sin and x1 = f*cos, rounds/saturates to Q5.11 and streams x0 then x1.
module box_muller_gauss_out #(
  parameter int MAG_W     = 16,
  parameter int MAG_FRAC  = 13,
  parameter int TRIG_W    = 16,
  parameter int TRIG_FRAC = 15,
  parameter int OUT_W     = 16,
  parameter int OUT_FRAC  = 11,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mag_valid,
  input  logic [MAG_W-1:0]  mag_in,
  output logic              mag_ready,
  input  logic              trig_valid,
  input  logic [TRIG_W-1:0] sin_in,
  input  logic [TRIG_W-1:0] cos_in,
  output logic              trig_ready,
  output logic              sample_valid,
  output logic [OUT_W-1:0]  sample_data,
  output logic              sample_idx,
  input  logic              sample_ready,
  output logic [CNT_W-1:0]  pair_count
);

  localparam int PROD_W = MAG_W + TRIG_W + 1;
  localparam int SUM_W  = PROD_W + 1;
  localparam int SHIFT  = MAG_FRAC + TRIG_FRAC - OUT_FRAC;

  localparam logic signed [SUM_W-1:0] ROUND_ADD =
    {{(SUM_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_MUL     = 2'd1,
    S_OUT0    = 2'd2,
    S_OUT1    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              mag_held_q, trig_held_q;
  logic [MAG_W-1:0]  mag_q;
  logic [TRIG_W-1:0] sin_q, cos_q;
  logic [OUT_W-1:0]  x0_q, x1_q, x0_d, x1_d;
  logic [CNT_W-1:0]  pair_count_q;

  logic mag_take, trig_take, pair_done;

  logic signed [PROD_W-1:0] prod0, prod1;
  logic signed [SUM_W-1:0]  sum0, sum1, shr0, shr1;

  // Readies decode registered state only, so no valid-to-ready path exists.
  assign mag_ready  = (state_q == S_COLLECT) && !mag_held_q;
  assign trig_ready = (state_q == S_COLLECT) && !trig_held_q;
  assign mag_take   = mag_valid && mag_ready;
  assign trig_take  = trig_valid && trig_ready;
  assign pair_done  = (state_q == S_OUT1) && sample_ready;
  assign pair_count = pair_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: begin
        if ((mag_held_q || mag_take) && (trig_held_q || trig_take)) begin
          state_d = S_MUL;
        end
      end
      S_MUL:  state_d = S_OUT0;
      S_OUT0: if (sample_ready) state_d = S_OUT1;
      S_OUT1: if (sample_ready) state_d = S_COLLECT;
      default: state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    sample_valid = 1'b0;
    sample_data  = '0;
    sample_idx   = 1'b0;
    case (state_q)
      S_OUT0: begin
        sample_valid = 1'b1;
        sample_data  = x0_q;
      end
      S_OUT1: begin
        sample_valid = 1'b1;
        sample_data  = x1_q;
        sample_idx   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_held_q  <= 1'b0;
      trig_held_q <= 1'b0;
      mag_q       <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
    end else begin
      if (mag_take) begin
        mag_held_q <= 1'b1;
        mag_q      <= mag_in;
      end
      if (trig_take) begin
        trig_held_q <= 1'b1;
        sin_q       <= sin_in;
        cos_q       <= cos_in;
      end
      if (pair_done) begin
        mag_held_q  <= 1'b0;
        trig_held_q <= 1'b0;
      end
    end
  end

  // Magnitude is unsigned, so it is zero-extended before the signed multiply.
  assign prod0 = $signed({1'b0, mag_q}) * $signed(sin_q);
  assign prod1 = $signed({1'b0, mag_q}) * $signed(cos_q);
  assign sum0  = $signed({prod0[PROD_W-1], prod0}) + ROUND_ADD;
  assign sum1  = $signed({prod1[PROD_W-1], prod1}) + ROUND_ADD;
  assign shr0  = sum0 >>> SHIFT;
  assign shr1  = sum1 >>> SHIFT;

  always_comb begin
    x0_d = shr0[OUT_W-1:0];
    if (shr0 > SAT_MAX)      x0_d = SAT_MAX[OUT_W-1:0];
    else if (shr0 < SAT_MIN) x0_d = SAT_MIN[OUT_W-1:0];
    x1_d = shr1[OUT_W-1:0];
    if (shr1 > SAT_MAX)      x1_d = SAT_MAX[OUT_W-1:0];
    else if (shr1 < SAT_MIN) x1_d = SAT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_q         <= '0;
      x1_q         <= '0;
      pair_count_q <= '0;
    end else begin
      if (state_q == S_MUL) begin
        x0_q <= x0_d;
        x1_q <= x1_d;
      end
      if (pair_done) begin
        pair_count_q <= pair_count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_box_muller_gauss_out.sv
// Scoreboard bench for box_muller_gauss_out (pair counter built 4 bits wide
// so the wrap can be reached quickly).
module tb_box_muller_gauss_out;

  logic        clk;
  logic        reset;
  logic        mag_valid;
  logic [15:0] mag_in;
  logic        mag_ready;
  logic        trig_valid;
  logic [15:0] sin_in;
  logic [15:0] cos_in;
  logic        trig_ready;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_idx;
  logic        sample_ready;
  logic [3:0]  pair_count;

  logic rdy_fix;
  logic rand_en;
  logic rand_bit;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] exp_pairs;
  bit         pc_pending;
  bit         prev_stall;
  logic [15:0] prev_data;
  logic       prev_idx;

  box_muller_gauss_out #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mag_valid    (mag_valid),
    .mag_in       (mag_in),
    .mag_ready    (mag_ready),
    .trig_valid   (trig_valid),
    .sin_in       (sin_in),
    .cos_in       (cos_in),
    .trig_ready   (trig_ready),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_idx   (sample_idx),
    .sample_ready (sample_ready),
    .pair_count   (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sample_ready = rand_en ? rand_bit : rdy_fix;

  always @(posedge clk) begin
    #1 rand_bit = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] m, input logic [15:0] t);
    longint p, r;
    p = longint'(m) * longint'($signed(t));
    r = (p + 64'sd65536) >>> 17;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  // Output monitor: scoreboard pop, stall stability and pair counter.
  always @(negedge clk) begin
    if (!reset) begin
      pc_pending = 0;
      prev_stall = 0;
    end else begin
      if (pc_pending) begin
        chk("pair_count", 32'(pair_count), 32'(exp_pairs));
        pc_pending = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(sample_valid), 32'd1);
        chk("stall_data", 32'(sample_data), 32'(prev_data));
        chk("stall_idx", 32'(sample_idx), 32'(prev_idx));
      end
      prev_stall = sample_valid && !sample_ready;
      prev_data  = sample_data;
      prev_idx   = sample_idx;
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample", 32'(sample_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sample_data", 32'(sample_data), 32'(e.data));
          chk("sample_idx", 32'(sample_idx), 32'(e.idx));
          if (e.idx) begin
            exp_pairs  = exp_pairs + 4'd1;
            pc_pending = 1;
          end
        end
      end
    end
  end

  // lead > 0: sin/cos leads by lead cycles; lead < 0: magnitude leads.
  task automatic send(input logic [15:0] m, input logic [15:0] s, input logic [15:0] c,
                      input int lead, input bit hold_trig);
    int mt, tt;
    bit md, td, ma, ta;
    exp_q.push_back('{data: model(m, s), idx: 1'b0});
    exp_q.push_back('{data: model(m, c), idx: 1'b1});
    mt = (lead > 0) ? lead : 0;
    tt = (lead < 0) ? -lead : 0;
    md = 0;
    td = 0;
    mag_in = m;
    sin_in = s;
    cos_in = c;
    for (int cyc = 0; cyc < 300 && !(md && td); cyc++) begin
      mag_valid  = !md && (cyc >= mt);
      trig_valid = (!td && (cyc >= tt)) || (hold_trig && td && !md);
      if (hold_trig && td && !md) chk("trig_ready_held", 32'(trig_ready), 32'd0);
      ma = mag_valid && mag_ready;
      ta = trig_valid && trig_ready && !td;
      @(posedge clk);
      #1;
      md = md | ma;
      td = td | ta;
    end
    mag_valid  = 1'b0;
    trig_valid = 1'b0;
    if (!(md && td)) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!sample_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!sample_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    mag_valid  = 1'b0;
    trig_valid = 1'b0;
    mag_in     = '0;
    sin_in     = '0;
    cos_in     = '0;
    rdy_fix    = 1'b1;
    rand_en    = 1'b0;
    exp_pairs  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_data", 32'(sample_data), 32'd0);
    chk("rst_idx", 32'(sample_idx), 32'd0);
    chk("rst_pairs", 32'(pair_count), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_mag_ready", 32'(mag_ready), 32'd1);
    chk("rel_trig_ready", 32'(trig_ready), 32'd1);

    // Basic pair with latency check.
    send(16'h2000, 16'h4000, 16'hC000, 0, 0);
    chk("lat_edge1", 32'(sample_valid), 32'd0);
    chk("lat_edge1_ready", 32'(mag_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_edge2", 32'(sample_valid), 32'd1);
    chk("basic_x0", 32'(sample_data), 32'h0400);
    drain();
    chk("basic_pairs", 32'(pair_count), 32'd1);

    // Trig first, held valid, with output backpressure.
    rdy_fix = 1'b0;
    send(16'h2000, 16'h4000, 16'hC000, 3, 1);
    wait_valid();
    repeat (5) begin
      chk("stall_x0", 32'(sample_data), 32'h0400);
      @(posedge clk);
      #1;
    end
    rdy_fix = 1'b1;
    drain();

    // Rounding, magnitude first, extremes.
    send(16'h0001, 16'h7FFF, 16'h7FFF, 0, 0);
    drain();
    send(16'h0003, 16'h7FFF, 16'h8001, -2, 0);
    drain();
    send(16'hFFFF, 16'h8000, 16'h7FFF, 1, 0);
    drain();

    // Random values under random backpressure.
    rand_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 4) - 2, 0);
    end
    drain();
    rand_en = 1'b0;

    // Reset in OUT0 discards the pair.
    rdy_fix = 1'b0;
    send(16'h1234, 16'h4321, 16'hBEEF, 0, 0);
    wait_valid();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(sample_valid), 32'd0);
    chk("mid_rst_pairs", 32'(pair_count), 32'd0);
    exp_q.delete();
    exp_pairs = '0;
    rdy_fix = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_mag_ready", 32'(mag_ready), 32'd1);
    chk("post_rst_trig_ready", 32'(trig_ready), 32'd1);
    chk("post_rst_valid", 32'(sample_valid), 32'd0);
    send(16'h2000, 16'hC000, 16'h4000, 0, 0);
    drain();

    // Counter wrap: 16 more pairs gives 2..15, 0, 1.
    for (int i = 0; i < 16; i++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom), 0, 0);
    end
    drain();
    chk("wrap_final", 32'(pair_count), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
